cu_sequencer: RTL and testbench

Program sequencer for the 16-bit-instruction compute unit. It accepts a program byte-serially over the 8-bit pin interface and stores it in a small instruction buffer. It then issues the instructions one at a time to the compute unit (cu_instr plus a one-cycle cu_en pulse), and captures each result beat. Run and single-step modes are supported; opcode 4'hF is a sequencer-level HALT.

---
 rtl/cu_pkg.sv | 24 ++
 rtl/cu_prog_buf.sv | 47 ++++
 rtl/cu_sequencer.sv | 127 ++++++++++++
 tb/tb_cu_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, instruction layout and sequencer states shared by the compute-unit sequencer
package cu_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NOT  = 4'h6,
        OP_XOR  = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] tgt;
        logic [3:0] src0;
        logic [3:0] src1;
    } instr_t;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HOLD, S_DONE} seq_state_t;
    function automatic logic [7:0] imm_of(input instr_t i);
        return {i.src0, i.src1};
    endfunction
endpackage

// File: rtl/cu_prog_buf.sv
// cu_prog_buf: program store assembling byte pairs into 16-bit words
//   load_en_i/byte_i/byte_valid_i : high byte first, low byte completes the word
//   rd_addr_i/rd_data_o          : asynchronous read of one slot
//   prog_len_o/overflow_o        : words stored; sticky flag for a word dropped while full
module cu_prog_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_en_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [15:0]   rd_data_o,
    output logic [AW:0]   prog_len_o,
    output logic          overflow_o
);
    logic [15:0] mem_q [DEPTH];
    logic [7:0]  hi_q;
    logic        tog_q;
    logic [AW:0] len_q;
    logic        ovf_q;
    logic        word_done, full;
    assign word_done = load_en_i && byte_valid_i && tog_q;
    assign full      = len_q == (AW+1)'(DEPTH);
    // leaving load mode drops the toggle, discarding a half-assembled word
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tog_q <= 1'b0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            tog_q <= load_en_i && (tog_q ^ byte_valid_i);
            if (word_done && !full) len_q <= len_q + 1'b1;
            if (word_done && full) ovf_q <= 1'b1;
        end
    end
    // storage is never cleared; prog_len alone defines the valid contents
    always_ff @(posedge clk) begin
        if (load_en_i && byte_valid_i && !tog_q) hi_q <= byte_i;
        if (word_done && !full) mem_q[len_q[AW-1:0]] <= {hi_q, byte_i};
    end
    assign rd_data_o  = mem_q[rd_addr_i];
    assign prog_len_o = len_q;
    assign overflow_o = ovf_q;
endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: loads a byte-serial program and issues it word by word to the compute unit
//   load    : load_mode, byte_in, byte_valid -> prog_len, overflow
//   control : start, step_mode, step -> busy, done, pc
//   unit    : cu_instr, cu_en out; cu_data, cu_data_valid, cu_reg_id in -> result, result_reg, result_valid
module cu_sequencer import cu_pkg::*; #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_mode,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    output logic [15:0]   cu_instr,
    output logic          cu_en,
    input  logic [7:0]    cu_data,
    input  logic          cu_data_valid,
    input  logic [3:0]    cu_reg_id,
    output logic [7:0]    result,
    output logic [3:0]    result_reg,
    output logic          result_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          busy,
    output logic          done,
    output logic          overflow
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    res_q, res_d;
    logic [3:0]    reg_q, reg_d;
    logic          rv_q, rv_d;
    logic [15:0]   rd_data;
    instr_t        fetched;
    logic          adv, last;
    cu_prog_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk          (clk),
        .rstn         (rstn),
        .load_en_i    (state_q == S_IDLE && load_mode),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .rd_addr_i    (pc_q),
        .rd_data_o    (rd_data),
        .prog_len_o   (prog_len),
        .overflow_o   (overflow)
    );
    assign fetched = rd_data;
    assign last    = {1'b0, pc_q} == prog_len - 1'b1;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            reg_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            reg_q   <= reg_d;
            rv_q    <= rv_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        reg_d   = reg_q;
        rv_d    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (start && !load_mode) begin
                pc_d    = '0;
                state_d = prog_len == '0 ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                instr_d = rd_data;
                state_d = fetched.op == OP_HALT ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cu_data_valid) begin
                    res_d = cu_data;
                    reg_d = cu_reg_id;
                    rv_d  = 1'b1;
                end
                // no response within the window is treated as a NOP
                adv = cu_data_valid || cnt_q == CW'(WAIT_CYCLES - 1);
            end
            S_HOLD: if (step) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (last) begin
                state_d = S_DONE;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = step_mode ? S_HOLD : S_FETCH;
            end
        end
    end
    assign cu_instr     = instr_q;
    assign cu_en        = state_q == S_ISSUE;
    assign result       = res_q;
    assign result_reg   = reg_q;
    assign result_valid = rv_q;
    assign pc           = pc_q;
    assign busy         = state_q != S_IDLE;
    assign done         = state_q == S_DONE;
endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: randomized and directed checks of cu_sequencer against a program-level model
module tb_cu_sequencer;
    import cu_pkg::*;
    localparam int DEPTH = 8, AW = 3, WAIT_CYCLES = 2;
    logic clk = 0, rstn = 0, load_mode = 0, byte_valid = 0, start = 0, step_mode = 0, step = 0;
    logic cu_data_valid = 0;
    logic [7:0] byte_in = 0, cu_data = 0;
    logic [3:0] cu_reg_id = 0;
    logic [15:0] cu_instr;
    logic cu_en, result_valid, busy, done, overflow;
    logic [7:0] result;
    logic [3:0] result_reg;
    logic [AW-1:0] pc;
    logic [AW:0] prog_len;
    int checks = 0, errors = 0, cyc = 0, t0 = 0, n_done = 0;
    logic [11:0] got_res[$];
    int en_cyc[$];
    logic [15:0] prog[$];
    logic [15:0] m_buf[DEPTH];
    int m_len = 0;
    bit m_ovf = 0;
    logic [7:0] cu_rf[16];
    logic noise = 0, rsp_pend = 0;
    logic [7:0] rsp_d = 0;
    logic [3:0] rsp_r = 0;
    instr_t cw;
    cu_sequencer #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rstn(rstn), .load_mode(load_mode), .byte_in(byte_in), .byte_valid(byte_valid),
        .start(start), .step_mode(step_mode), .step(step), .cu_instr(cu_instr), .cu_en(cu_en),
        .cu_data(cu_data), .cu_data_valid(cu_data_valid), .cu_reg_id(cu_reg_id), .result(result),
        .result_reg(result_reg), .result_valid(result_valid), .pc(pc), .prog_len(prog_len),
        .busy(busy), .done(done), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign cw = cu_instr;

    function automatic logic [7:0] alu(input instr_t w, input logic [7:0] a, input logic [7:0] b);
        case (w.op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOT:  return ~a;
            OP_XOR:  return a ^ b;
            default: return imm_of(w);
        endcase
    endfunction

    // compute unit: answers one cycle after cu_en with the new target value; NOP never answers
    always @(posedge clk) begin
        #1;
        cu_data_valid = rsp_pend | noise;
        cu_data = rsp_pend ? rsp_d : 8'hEE;
        cu_reg_id = rsp_pend ? rsp_r : 4'hE;
        rsp_pend = cu_en && cw.op != OP_NOP;
        if (cu_en && cw.op != OP_NOP) begin
            rsp_d = alu(cw, cu_rf[cw.src0], cu_rf[cw.src1]);
            rsp_r = cw.tgt;
            cu_rf[cw.tgt] = rsp_d;
        end
    end

    always @(negedge clk) begin
        if (cu_en) en_cyc.push_back(cyc - t0);
        if (result_valid) got_res.push_back({result_reg, result});
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 0;
        noise = 0;
        tick(2);
        rstn = 1;
        tick(1);
        m_len = 0;
        m_ovf = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1;
        tick(1);
        byte_valid = 0;
        tick($urandom_range(0, 2));
    endtask

    task automatic load_prog(input string tag);
        load_mode = 1;
        tick(1);
        foreach (prog[i]) begin
            send_byte(prog[i][15:8]);
            send_byte(prog[i][7:0]);
            if (m_len == DEPTH) m_ovf = 1;
            else m_buf[m_len++] = prog[i];
        end
        load_mode = 0;
        tick(1);
        check({tag, ".len"}, prog_len, m_len);
        check({tag, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic run(input bit stepm, input string tag);
        int exp_en[$];
        logic [11:0] exp_res[$];
        logic [7:0] m_rf[16];
        instr_t w;
        int t, exp_pc, budget;
        logic [7:0] v;
        t = 2;
        exp_pc = 0;
        for (int r = 0; r < 16; r++) begin
            m_rf[r] = 0;
            cu_rf[r] = 0;
        end
        for (int i = 0; i < m_len; i++) begin
            w = m_buf[i];
            exp_pc = i;
            if (w.op == OP_HALT) break;
            exp_en.push_back(t);
            if (w.op == OP_NOP) begin
                t += WAIT_CYCLES + 2;
            end else begin
                v = alu(w, m_rf[w.src0], m_rf[w.src1]);
                m_rf[w.tgt] = v;
                exp_res.push_back({w.tgt, v});
                t += 3;
            end
        end
        got_res.delete();
        en_cyc.delete();
        n_done = 0;
        step_mode = stepm;
        start = 1;
        t0 = cyc;
        tick(1);
        start = 0;
        budget = 0;
        while (busy && budget < 400) begin
            if (stepm && budget % 8 == 7) step = 1;
            tick(1);
            step = 0;
            budget++;
        end
        check({tag, ".timeout"}, budget < 400, 1);
        check({tag, ".done"}, n_done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".issues"}, en_cyc.size(), exp_en.size());
        check({tag, ".nres"}, got_res.size(), exp_res.size());
        foreach (exp_res[i])
            check($sformatf("%s.res%0d", tag, i), i < got_res.size() ? got_res[i] : 12'hFFF, exp_res[i]);
        if (!stepm)
            foreach (exp_en[i])
                check($sformatf("%s.en%0d", tag, i), i < en_cyc.size() ? en_cyc[i] : -1, exp_en[i]);
        if (m_len > 0) check({tag, ".pc"}, pc, exp_pc);
    endtask

    initial begin
        logic [3:0] ops[8];
        instr_t w;
        int n, ne;
        ops = '{OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR};
        do_reset();
        check("rst.busy", busy, 0);
        check("rst.cu_en", cu_en, 0);
        check("rst.len", prog_len, 0);
        check("rst.pc", pc, 0);
        check("rst.done", done, 0);
        check("rst.ovf", overflow, 0);

        prog = '{16'h1105, 16'h1203, 16'h2312};
        load_prog("basic");
        run(0, "basic");
        check("basic.r2", got_res.size() > 2 ? got_res[2] : 12'hFFF, 12'h308);
        check("basic.e2", en_cyc.size() > 2 ? en_cyc[2] : -1, 8);

        do_reset();
        prog = '{16'h1105, 16'h0000, 16'h1207};
        load_prog("nop");
        run(0, "nop");
        check("nop.e2", en_cyc.size() > 2 ? en_cyc[2] : -1, 9);

        do_reset();
        prog = '{16'h1101, 16'hF000, 16'h1202};
        load_prog("halt");
        run(0, "halt");
        check("halt.pc", pc, 1);

        do_reset();
        prog = '{16'h1105, 16'h1203, 16'h2312};
        load_prog("step");
        for (int r = 0; r < 16; r++) cu_rf[r] = 0;
        got_res.delete();
        en_cyc.delete();
        n_done = 0;
        step_mode = 1;
        start = 1;
        t0 = cyc;
        tick(1);
        start = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (got_res.size() < k + 1 && n < 40) begin
                tick(1);
                n++;
            end
            check($sformatf("step.wait%0d", k), n < 40, 1);
            if (k < 2) begin
                ne = en_cyc.size();
                tick(3);
                noise = 1;
                tick(3);
                noise = 0;
                tick(4);
                check($sformatf("step.hold_en%0d", k), en_cyc.size(), ne);
                check($sformatf("step.hold_busy%0d", k), busy, 1);
                check($sformatf("step.noise%0d", k), got_res.size(), k + 1);
                step = 1;
                tick(1);
                step = 0;
            end
        end
        tick(4);
        check("step.busy", busy, 0);
        check("step.done", n_done, 1);
        check("step.r0", got_res.size() > 0 ? got_res[0] : 12'hFFF, 12'h105);
        check("step.r1", got_res.size() > 1 ? got_res[1] : 12'hFFF, 12'h203);
        check("step.r2", got_res.size() > 2 ? got_res[2] : 12'hFFF, 12'h308);
        ne = en_cyc.size();
        step = 1;
        tick(1);
        step = 0;
        tick(5);
        check("step.idle_en", en_cyc.size(), ne);
        check("step.idle_busy", busy, 0);

        do_reset();
        prog = {};
        for (int i = 0; i < 9; i++) prog.push_back({8'h10 | 8'(i % 8), 8'(i + 1)});
        load_prog("ovf");
        run(0, "ovf");

        do_reset();
        load_mode = 1;
        tick(1);
        send_byte(8'h12);
        load_mode = 0;
        tick(1);
        prog = '{16'h1105, 16'h1207};
        load_prog("align");
        run(0, "align");

        do_reset();
        run(0, "empty");
        check("empty.ne", en_cyc.size(), 0);

        do_reset();
        prog = '{16'h1105, 16'h1203, 16'h2312};
        load_prog("abort");
        en_cyc.delete();
        t0 = cyc;
        step_mode = 0;
        start = 1;
        tick(1);
        start = 0;
        n = 0;
        while (en_cyc.size() < 2 && n < 40) begin
            tick(1);
            n++;
        end
        check("abort.wait", n < 40, 1);
        rstn = 0;
        tick(1);
        check("abort.cu_en", cu_en, 0);
        check("abort.busy", busy, 0);
        check("abort.instr", cu_instr, 0);
        check("abort.result", {result_reg, result, result_valid}, 0);
        check("abort.pc", pc, 0);
        check("abort.len", prog_len, 0);
        check("abort.done", done, 0);
        rstn = 1;
        m_len = 0;
        m_ovf = 0;
        tick(1);
        run(0, "abort_empty");

        for (int it = 0; it < 20; it++) begin
            do_reset();
            prog = {};
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                w.op = $urandom_range(0, 9) == 0 ? OP_HALT : ops[$urandom_range(0, 7)];
                prog.push_back(w);
            end
            load_prog($sformatf("rnd%0d", it));
            run(1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
